// File: rtl/bcd_time_counter.sv
// M:SS.t timekeeping core: start/stop/clear/load controls, count up or down in tenths.
// Define LAP_HOLD_EN to add the Lap input that freezes the digit outputs while counting continues.
module bcd_time_counter #(
    parameter int TENTH_DIV = 5000000,
    parameter int DIV_W     = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Clear,
    input  logic       Countdown,
    input  logic       Load,
`ifdef LAP_HOLD_EN
    input  logic       Lap,
`endif
    input  logic [3:0] Preset_Minutes,
    input  logic [3:0] Preset_Tens,
    input  logic [3:0] Preset_Ones,
    output logic [3:0] Minutes,
    output logic [3:0] Tens_Seconds,
    output logic [3:0] Ones_Seconds,
    output logic [3:0] Tenths_Seconds,
    output logic       Running,
    output logic       Done,
    output logic       Overflow
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

    localparam logic [DIV_W-1:0] LAST = DIV_W'(TENTH_DIV - 1);

    state_t           state_q;
    logic [DIV_W-1:0] presc_q;
    logic             dir_q;
    logic [3:0]       min_q, tens_q, ones_q, tenths_q;
    logic             start_q, stop_q, clear_q, load_q, armed_q;

    logic       start_e, stop_e, clear_e, load_e;
    logic       at_zero, tick, dn_zero, up_wrap;
    logic [3:0] up_min, up_tens, up_ones, up_tenths;
    logic [3:0] dn_min, dn_tens, dn_ones, dn_tenths;
    logic [3:0] ld_min, ld_tens, ld_ones;

    // armed_q masks the first cycle after reset so a level already high is not taken as an edge
    assign start_e = armed_q & Start & ~start_q;
    assign stop_e  = armed_q & Stop  & ~stop_q;
    assign clear_e = armed_q & Clear & ~clear_q;
    assign load_e  = armed_q & Load  & ~load_q;

    assign at_zero = ({min_q, tens_q, ones_q, tenths_q} == 16'd0);
    assign tick    = (state_q == S_RUN) && !clear_e && !stop_e && (presc_q == LAST);

    assign ld_min  = (Preset_Minutes > 4'd9) ? 4'd9 : Preset_Minutes;
    assign ld_tens = (Preset_Tens    > 4'd5) ? 4'd5 : Preset_Tens;
    assign ld_ones = (Preset_Ones    > 4'd9) ? 4'd9 : Preset_Ones;

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        up_min    = min_q;
        up_tens   = tens_q;
        up_ones   = ones_q;
        up_tenths = tenths_q;
        up_wrap   = 1'b0;
        if (tenths_q != 4'd9) begin
            up_tenths = tenths_q + 4'd1;
        end else begin
            up_tenths = 4'd0;
            if (ones_q != 4'd9) begin
                up_ones = ones_q + 4'd1;
            end else begin
                up_ones = 4'd0;
                if (tens_q != 4'd5) begin
                    up_tens = tens_q + 4'd1;
                end else begin
                    up_tens = 4'd0;
                    if (min_q != 4'd9) begin
                        up_min = min_q + 4'd1;
                    end else begin
                        up_min  = 4'd0;
                        up_wrap = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        dn_min    = min_q;
        dn_tens   = tens_q;
        dn_ones   = ones_q;
        dn_tenths = tenths_q;
        if (tenths_q != 4'd0) begin
            dn_tenths = tenths_q - 4'd1;
        end else begin
            dn_tenths = 4'd9;
            if (ones_q != 4'd0) begin
                dn_ones = ones_q - 4'd1;
            end else begin
                dn_ones = 4'd9;
                if (tens_q != 4'd0) begin
                    dn_tens = tens_q - 4'd1;
                end else begin
                    dn_tens = 4'd5;
                    dn_min  = min_q - 4'd1;
                end
            end
        end
        dn_zero = ({dn_min, dn_tens, dn_ones, dn_tenths} == 16'd0);
    end

    // NOTE: state registers use non-blocking assignments and reset asynchronously on reset low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            dir_q    <= 1'b0;
            min_q    <= 4'd0;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            tenths_q <= 4'd0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            clear_q  <= 1'b0;
            load_q   <= 1'b0;
            armed_q  <= 1'b0;
            Running  <= 1'b0;
            Done     <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            start_q  <= Start;
            stop_q   <= Stop;
            clear_q  <= Clear;
            load_q   <= Load;
            armed_q  <= 1'b1;
            Overflow <= 1'b0;
            if (clear_e) begin
                state_q  <= S_IDLE;
                presc_q  <= '0;
                min_q    <= 4'd0;
                tens_q   <= 4'd0;
                ones_q   <= 4'd0;
                tenths_q <= 4'd0;
                Running  <= 1'b0;
                Done     <= 1'b0;
            end else if (stop_e && state_q == S_RUN) begin
                // prescaler keeps its phase so resuming continues the interrupted tenth
                state_q <= S_PAUSED;
                Running <= 1'b0;
            end else if (load_e && state_q != S_RUN) begin
                state_q  <= S_IDLE;
                presc_q  <= '0;
                min_q    <= ld_min;
                tens_q   <= ld_tens;
                ones_q   <= ld_ones;
                tenths_q <= 4'd0;
                Running  <= 1'b0;
                Done     <= 1'b0;
            end else if (start_e && (state_q == S_IDLE || state_q == S_PAUSED)
                         && !(Countdown && at_zero)) begin
                state_q <= S_RUN;
                dir_q   <= Countdown;
                Running <= 1'b1;
            end else if (state_q == S_RUN) begin
                if (tick) begin
                    presc_q <= '0;
                    if (dir_q) begin
                        {min_q, tens_q, ones_q, tenths_q} <= {dn_min, dn_tens, dn_ones, dn_tenths};
                        if (dn_zero) begin
                            state_q <= S_DONE;
                            Running <= 1'b0;
                            Done    <= 1'b1;
                        end
                    end else begin
                        {min_q, tens_q, ones_q, tenths_q} <= {up_min, up_tens, up_ones, up_tenths};
                        Overflow <= up_wrap;
                    end
                end else begin
                    presc_q <= presc_q + DIV_W'(1);
                end
            end
        end
    end

`ifdef LAP_HOLD_EN
    logic       lap_q, hold_q, lap_e, enter_done;
    logic [3:0] cap_min, cap_tens, cap_ones, cap_tenths;

    assign lap_e      = armed_q & Lap & ~lap_q;
    assign enter_done = tick & dir_q & dn_zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_q      <= 1'b0;
            hold_q     <= 1'b0;
            cap_min    <= 4'd0;
            cap_tens   <= 4'd0;
            cap_ones   <= 4'd0;
            cap_tenths <= 4'd0;
        end else begin
            lap_q <= Lap;
            if (clear_e || (load_e && state_q != S_RUN) || enter_done) begin
                hold_q <= 1'b0;
            end else if (lap_e && state_q == S_RUN) begin
                hold_q <= ~hold_q;
                if (!hold_q) begin
                    {cap_min, cap_tens, cap_ones, cap_tenths} <= {min_q, tens_q, ones_q, tenths_q};
                end
            end
        end
    end

    assign Minutes        = hold_q ? cap_min    : min_q;
    assign Tens_Seconds   = hold_q ? cap_tens   : tens_q;
    assign Ones_Seconds   = hold_q ? cap_ones   : ones_q;
    assign Tenths_Seconds = hold_q ? cap_tenths : tenths_q;
`else
    assign Minutes        = min_q;
    assign Tens_Seconds   = tens_q;
    assign Ones_Seconds   = ones_q;
    assign Tenths_Seconds = tenths_q;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Self-checking bench for bcd_time_counter: directed scenarios plus randomized controls
// compared against a model that keeps time as an integer count of tenths.
module tb_bcd_time_counter;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       Start = 1'b0, Stop = 1'b0, Clear = 1'b0, Countdown = 1'b0, Load = 1'b0;
    logic [3:0] Preset_Minutes = 4'd0, Preset_Tens = 4'd0, Preset_Ones = 4'd0;
    logic [3:0] Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds;
    logic       Running, Done, Overflow;

    int tests = 0;
    int fails = 0;

    logic [15:0] digits;
    logic [18:0] obs;
    assign digits = {Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds};
    assign obs    = {digits, Running, Done, Overflow};

    always #5 clk = ~clk;

    bcd_time_counter #(.TENTH_DIV(DIV), .DIV_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .Start          (Start),
        .Stop           (Stop),
        .Clear          (Clear),
        .Countdown      (Countdown),
        .Load           (Load),
        .Preset_Minutes (Preset_Minutes),
        .Preset_Tens    (Preset_Tens),
        .Preset_Ones    (Preset_Ones),
        .Minutes        (Minutes),
        .Tens_Seconds   (Tens_Seconds),
        .Ones_Seconds   (Ones_Seconds),
        .Tenths_Seconds (Tenths_Seconds),
        .Running        (Running),
        .Done           (Done),
        .Overflow       (Overflow)
    );

    // Reference model: time is an integer number of tenths (0..5999), phase counts run cycles.
    typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_DONE} mstate_t;
    mstate_t m_state;
    int      m_time, m_phase;
    bit      m_dir, m_ovf, m_armed;
    bit      m_ps, m_pt, m_pc, m_pl;
    bit      se, te, ce, le;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state = M_IDLE;
            m_time  = 0;
            m_phase = 0;
            m_dir   = 0;
            m_ovf   = 0;
            m_armed = 0;
            {m_ps, m_pt, m_pc, m_pl} = 4'b0;
        end else begin
            se = m_armed && Start && !m_ps;
            te = m_armed && Stop  && !m_pt;
            ce = m_armed && Clear && !m_pc;
            le = m_armed && Load  && !m_pl;
            m_ovf = 0;
            if (ce) begin
                m_state = M_IDLE; m_time = 0; m_phase = 0;
            end else if (te && m_state == M_RUN) begin
                m_state = M_PAUSED;
            end else if (le && m_state != M_RUN) begin
                m_state = M_IDLE;
                m_phase = 0;
                m_time  = ((Preset_Minutes > 9) ? 9 : int'(Preset_Minutes)) * 600
                        + ((Preset_Tens > 5) ? 5 : int'(Preset_Tens)) * 100
                        + ((Preset_Ones > 9) ? 9 : int'(Preset_Ones)) * 10;
            end else if (se && (m_state == M_IDLE || m_state == M_PAUSED)
                         && !(Countdown && m_time == 0)) begin
                m_state = M_RUN;
                m_dir   = Countdown;
            end else if (m_state == M_RUN) begin
                if (m_phase == DIV - 1) begin
                    m_phase = 0;
                    if (m_dir) begin
                        m_time = m_time - 1;
                        if (m_time == 0) m_state = M_DONE;
                    end else begin
                        m_time = m_time + 1;
                        if (m_time == 6000) begin
                            m_time = 0;
                            m_ovf  = 1;
                        end
                    end
                end else begin
                    m_phase = m_phase + 1;
                end
            end
            {m_ps, m_pt, m_pc, m_pl} = {Start, Stop, Clear, Load};
            m_armed = 1;
        end
    end

    function automatic logic [18:0] model_vec();
        return {4'(m_time / 600), 4'((m_time / 100) % 6), 4'((m_time / 10) % 10), 4'(m_time % 10),
                m_state == M_RUN, m_state == M_DONE, m_ovf};
    endfunction

    task automatic pulse(input bit s, input bit t, input bit c, input bit l);
        {Start, Stop, Clear, Load} = {s, t, c, l};
        @(negedge clk);
        {Start, Stop, Clear, Load} = 4'b0;
    endtask

    task automatic set_presets(input int m, input int t, input int o);
        Preset_Minutes = 4'(m);
        Preset_Tens    = 4'(t);
        Preset_Ones    = 4'(o);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        Start = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (obs !== 19'd0) begin fails++; $display("FAIL reset_state: got %h want 0", obs); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (Running !== 1'b0 || digits !== 16'h0000) begin
            fails++; $display("FAIL held_start_not_edge: running=%b digits=%h want 0/0000", Running, digits);
        end
        Start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_count_up();
        Countdown = 1'b0;
        pulse(1, 0, 0, 0);
        repeat (40) @(negedge clk);
        tests++;
        if ({digits, Running, Overflow} !== {16'h0010, 1'b1, 1'b0}) begin
            fails++; $display("FAIL up_one_second: got %h run=%b ovf=%b want 0010 run=1 ovf=0", digits, Running, Overflow);
        end
        tests++;
        if (obs !== model_vec()) begin fails++; $display("FAIL up_model: got %h want %h", obs, model_vec()); end
    endtask

    task automatic test_tens_carry();
        pulse(0, 0, 1, 0);
        set_presets(0, 5, 9);
        pulse(0, 0, 0, 1);
        tests++;
        if (digits !== 16'h0590) begin fails++; $display("FAIL load_059: got %h want 0590", digits); end
        Countdown = 1'b0;
        pulse(1, 0, 0, 0);
        repeat (4) @(negedge clk);
        tests++;
        if (digits !== 16'h0591) begin fails++; $display("FAIL first_tick: got %h want 0591", digits); end
        repeat (36) @(negedge clk);
        tests++;
        if ({digits, Running} !== {16'h1000, 1'b1}) begin
            fails++; $display("FAIL tens_carry: got %h run=%b want 1000 run=1", digits, Running);
        end
    endtask

    task automatic test_countdown_done();
        pulse(0, 0, 1, 0);
        set_presets(0, 0, 1);
        pulse(0, 0, 0, 1);
        Countdown = 1'b1;
        pulse(1, 0, 0, 0);
        repeat (39) @(negedge clk);
        tests++;
        if ({digits, Running, Done} !== {16'h0001, 1'b1, 1'b0}) begin
            fails++; $display("FAIL down_before_zero: got %h run=%b done=%b want 0001 1 0", digits, Running, Done);
        end
        @(negedge clk);
        tests++;
        if ({digits, Running, Done} !== {16'h0000, 1'b0, 1'b1}) begin
            fails++; $display("FAIL down_done: got %h run=%b done=%b want 0000 0 1", digits, Running, Done);
        end
        Countdown = 1'b0;
        pulse(1, 0, 0, 0);
        repeat (8) @(negedge clk);
        tests++;
        if ({digits, Running, Done} !== {16'h0000, 1'b0, 1'b1}) begin
            fails++; $display("FAIL start_in_done: got %h run=%b done=%b want 0000 0 1", digits, Running, Done);
        end
    endtask

    task automatic test_overflow();
        set_presets(9, 5, 9);
        pulse(0, 0, 0, 1);
        tests++;
        if ({digits, Done} !== {16'h9590, 1'b0}) begin
            fails++; $display("FAIL load_from_done: got %h done=%b want 9590 0", digits, Done);
        end
        Countdown = 1'b0;
        pulse(1, 0, 0, 0);
        repeat (39) @(negedge clk);
        tests++;
        if ({digits, Overflow} !== {16'h9599, 1'b0}) begin
            fails++; $display("FAIL before_wrap: got %h ovf=%b want 9599 0", digits, Overflow);
        end
        @(negedge clk);
        tests++;
        if ({digits, Running, Overflow} !== {16'h0000, 1'b1, 1'b1}) begin
            fails++; $display("FAIL wrap: got %h run=%b ovf=%b want 0000 1 1", digits, Running, Overflow);
        end
        @(negedge clk);
        tests++;
        if ({digits, Running, Overflow} !== {16'h0000, 1'b1, 1'b0}) begin
            fails++; $display("FAIL ovf_one_cycle: got %h run=%b ovf=%b want 0000 1 0", digits, Running, Overflow);
        end
    endtask

    task automatic test_stop_resume();
        @(negedge clk);
        pulse(0, 1, 0, 0);
        repeat (100) @(negedge clk);
        tests++;
        if ({digits, Running} !== {16'h0000, 1'b0}) begin
            fails++; $display("FAIL paused: got %h run=%b want 0000 0", digits, Running);
        end
        pulse(1, 0, 0, 0);
        tests++;
        if ({digits, Running} !== {16'h0000, 1'b1}) begin
            fails++; $display("FAIL resume_0: got %h run=%b want 0000 1", digits, Running);
        end
        @(negedge clk);
        tests++;
        if (digits !== 16'h0000) begin fails++; $display("FAIL resume_1: got %h want 0000", digits); end
        @(negedge clk);
        tests++;
        if (digits !== 16'h0001) begin fails++; $display("FAIL resume_phase: got %h want 0001", digits); end
        pulse(0, 1, 1, 0);
        tests++;
        if ({digits, Running, Done} !== {16'h0000, 1'b0, 1'b0}) begin
            fails++; $display("FAIL stop_clear: got %h run=%b done=%b want 0000 0 0", digits, Running, Done);
        end
    endtask

    task automatic test_clamp_and_reset();
        set_presets(12, 7, 15);
        pulse(0, 0, 0, 1);
        tests++;
        if (digits !== 16'h9590) begin fails++; $display("FAIL clamp: got %h want 9590", digits); end
        Countdown = 1'b0;
        pulse(1, 0, 0, 0);
        set_presets(1, 2, 3);
        pulse(0, 0, 0, 1);
        repeat (2) @(negedge clk);
        tests++;
        if ({digits[15:4], Running} !== {12'h959, 1'b1}) begin
            fails++; $display("FAIL load_in_run: got %h run=%b want 959x 1", digits, Running);
        end
        tests++;
        if (obs !== model_vec()) begin fails++; $display("FAIL load_in_run_model: got %h want %h", obs, model_vec()); end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (obs !== 19'd0) begin fails++; $display("FAIL async_reset: got %h want 0", obs); end
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        tests++;
        if (obs !== 19'd0) begin fails++; $display("FAIL after_reset_release: got %h want 0", obs); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            Start     = ($urandom_range(0, 9) == 0);
            Stop      = ($urandom_range(0, 29) == 0);
            Clear     = ($urandom_range(0, 149) == 0);
            Load      = ($urandom_range(0, 59) == 0);
            Countdown = 1'($urandom_range(0, 1));
            set_presets($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            @(negedge clk);
            tests++;
            if (obs !== model_vec()) begin
                fails++; $display("FAIL random cycle %0d: got %h want %h", i, obs, model_vec());
            end
        end
        {Start, Stop, Clear, Load} = 4'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_count_up();
        test_tens_carry();
        test_countdown_done();
        test_overflow();
        test_stop_resume();
        test_clamp_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
